robot_nav_ctrl: RTL and testbench

- Parametrised second-generation controller for the pipe-cleaning robot. It follows the wall on either side, selected by parameter.
- Removes barriers using a configurable number of removal cycles. Enforces a move budget and detects a boxed-in (stalled) robot.
- Sits between the robot sensor block and the motion/cleaning actuators, and issues at most one action per clock.

---
 rtl/robot_nav_ctrl.sv | 153 +++++++++++++++
 tb/tb_robot_nav_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/robot_nav_ctrl.sv
// Wall-following navigation controller for the pipe-cleaning robot: walks, turns,
// removes barriers, and stops on target, move budget or stall.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// WALK     | following the wall on side S, one action per cycle
// GAP      | just turned into a gap; must advance or turn away, never turn_S again
// REMOVING | removal tool held for the remaining REMOVE_CYCLES-1 cycles
// DONE     | mission ended (target, budget or stall), absorbing until reset
module robot_nav_ctrl #(
    parameter int FOLLOW_SIDE   = 0,
    parameter int REMOVE_CYCLES = 3,
    parameter int CNT_W         = 9,
    parameter int STALL_LIMIT   = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             head,
    input  logic             side,
    input  logic             barrier,
    input  logic             under,
    input  logic [CNT_W-1:0] max_moves,
    output logic             front,
    output logic             turn_left,
    output logic             turn_right,
    output logic             remove,
    output logic             done,
    output logic             stuck,
    output logic [CNT_W-1:0] action_count,
    output logic [CNT_W-1:0] removed_count
);

    localparam int RC_W = (REMOVE_CYCLES > 1) ? $clog2(REMOVE_CYCLES + 1) : 1;
    localparam int SL_W = $clog2(STALL_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {WALK, GAP, REMOVING, DONE} state_t;

    state_t            state, state_nxt;
    logic [RC_W-1:0]   rcnt, rcnt_nxt;
    logic [SL_W-1:0]   stall, stall_nxt;
    logic              stall_flag;
    logic              act_front, act_ts, act_to, act_rem;
    logic              rem_fin, stall_hit, budget_hit, any_act;
    logic [CNT_W-1:0]  act_inc;

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= WALK;
            rcnt          <= '0;
            stall         <= '0;
            stall_flag    <= 1'b0;
            front         <= 1'b0;
            turn_left     <= 1'b0;
            turn_right    <= 1'b0;
            remove        <= 1'b0;
            done          <= 1'b0;
            stuck         <= 1'b0;
            action_count  <= '0;
            removed_count <= '0;
        end else begin
            state      <= state_nxt;
            rcnt       <= rcnt_nxt;
            stall      <= stall_nxt;
            front      <= act_front;
            turn_left  <= (FOLLOW_SIDE == 0) ? act_ts : act_to;
            turn_right <= (FOLLOW_SIDE == 0) ? act_to : act_ts;
            remove     <= act_rem;
            if (any_act)
                action_count <= act_inc;
            if (rem_fin && removed_count != CNT_MAX)
                removed_count <= removed_count + 1'b1;
            if (stall_hit)
                stall_flag <= 1'b1;
            // done/stuck surface one cycle after the FSM lands in DONE
            if (enable && state == DONE) begin
                done  <= 1'b1;
                stuck <= stall_flag;
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        rcnt_nxt   = rcnt;
        stall_nxt  = stall;
        act_front  = 1'b0;
        act_ts     = 1'b0;
        act_to     = 1'b0;
        act_rem    = 1'b0;
        rem_fin    = 1'b0;
        stall_hit  = 1'b0;
        budget_hit = 1'b0;

        if (enable) begin
            case (state)
                WALK, GAP: begin
                    if (under) begin
                        state_nxt = DONE;
                    end else if (state == WALK && !side) begin
                        act_ts    = 1'b1;
                        state_nxt = GAP;
                    end else if (!head) begin
                        act_front = 1'b1;
                        state_nxt = WALK;
                    end else if (barrier) begin
                        act_rem = 1'b1;
                        if (REMOVE_CYCLES == 1) begin
                            rem_fin   = 1'b1;
                            state_nxt = WALK;
                        end else begin
                            rcnt_nxt  = RC_W'(1);
                            state_nxt = REMOVING;
                        end
                    end else begin
                        act_to    = 1'b1;
                        state_nxt = WALK;
                    end
                end
                REMOVING: begin
                    act_rem  = 1'b1;
                    rcnt_nxt = rcnt + 1'b1;
                    if (rcnt_nxt == RC_W'(REMOVE_CYCLES)) begin
                        rem_fin   = 1'b1;
                        state_nxt = WALK;
                    end
                end
                DONE: ;
            endcase
        end

        if (act_ts || act_to) begin
            stall_nxt = stall + 1'b1;
            if (stall_nxt == SL_W'(STALL_LIMIT)) begin
                stall_hit = 1'b1;
                state_nxt = DONE;
            end
        end else if (act_front || act_rem) begin
            stall_nxt = '0;
        end

        any_act = act_front | act_ts | act_to | act_rem;
        act_inc = (action_count == CNT_MAX) ? action_count : action_count + 1'b1;
        // budget hit still issues the action but truncates any removal in flight
        if (any_act && max_moves != '0 && act_inc == max_moves) begin
            budget_hit = 1'b1;
            rem_fin    = 1'b0;
            state_nxt  = DONE;
        end
    end

endmodule

// File: tb/tb_robot_nav_ctrl.sv
// Directed bench for robot_nav_ctrl: a left-follower and a right-follower share
// one stimulus stream and are compared against hand-computed expectations.
module tb_robot_nav_ctrl;

    logic       clock = 1'b0;
    logic       reset, enable, head, side, barrier, under;
    logic [8:0] max_moves;

    logic       f0, tl0, tr0, rm0, done0, stuck0;
    logic [8:0] ac0, rc0;
    logic       f1, tl1, tr1, rm1, done1, stuck1;
    logic [8:0] ac1, rc1;

    int n_vec = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    robot_nav_ctrl #(.FOLLOW_SIDE(0), .REMOVE_CYCLES(3), .CNT_W(9), .STALL_LIMIT(4)) dut0 (
        .clock(clock), .reset(reset), .enable(enable), .head(head), .side(side),
        .barrier(barrier), .under(under), .max_moves(max_moves),
        .front(f0), .turn_left(tl0), .turn_right(tr0), .remove(rm0),
        .done(done0), .stuck(stuck0), .action_count(ac0), .removed_count(rc0)
    );

    robot_nav_ctrl #(.FOLLOW_SIDE(1), .REMOVE_CYCLES(3), .CNT_W(9), .STALL_LIMIT(4)) dut1 (
        .clock(clock), .reset(reset), .enable(enable), .head(head), .side(side),
        .barrier(barrier), .under(under), .max_moves(max_moves),
        .front(f1), .turn_left(tl1), .turn_right(tr1), .remove(rm1),
        .done(done1), .stuck(stuck1), .action_count(ac1), .removed_count(rc1)
    );

    // action vectors packed as {front, turn_left, turn_right, remove}
    localparam int A_NONE = 4'b0000;
    localparam int A_FWD  = 4'b1000;
    localparam int A_TL   = 4'b0100;
    localparam int A_TR   = 4'b0010;
    localparam int A_REM  = 4'b0001;

    function automatic int act0();
        return {28'd0, f0, tl0, tr0, rm0};
    endfunction

    function automatic int act1();
        return {28'd0, f1, tl1, tr1, rm1};
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic sense(input logic s, input logic h, input logic b, input logic u);
        side    = s;
        head    = h;
        barrier = b;
        under   = u;
    endtask

    task automatic do_reset(input logic [8:0] mm);
        reset     = 1'b1;
        enable    = 1'b1;
        max_moves = mm;
        sense(1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; max_moves = '0;
        sense(1'b0, 1'b0, 1'b0, 1'b0);
        tick(); tick();
        check("rst_act", act0(), A_NONE);
        check("rst_done", {31'd0, done0, stuck0}, 0);
        check("rst_acnt", ac0, 0);
        check("rst_rcnt", rc0, 0);

        // free corridor along the wall
        reset = 1'b0;
        sense(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("corr_fwd", act0(), A_FWD);
        end
        check("corr_acnt", ac0, 5);

        // gap: turn_S then forced advance
        sense(1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        check("gap_turn0", act0(), A_TL);
        check("gap_turn1", act1(), A_TR);
        sense(1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check("gap_fwd", act0(), A_FWD);
        sense(1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        check("gap_fwd2", act0(), A_FWD);
        check("gap_acnt", ac0, 8);

        // barrier removal, sensors ignored mid-removal
        sense(1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        check("rem_c1", act0(), A_REM);
        sense(1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check("rem_c2", act0(), A_REM);
        check("rem_mid_rcnt", rc0, 0);
        tick();
        check("rem_c3", act0(), A_REM);
        sense(1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        check("rem_after", act0(), A_FWD);
        check("rem_rcnt", rc0, 1);
        check("rem_acnt", ac0, 12);

        // enable low freezes a removal in progress
        sense(1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        check("frz_c1", act0(), A_REM);
        enable = 1'b0;
        sense(1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        check("frz_off1", act0(), A_NONE);
        tick();
        check("frz_off2", act0(), A_NONE);
        check("frz_acnt", ac0, 13);
        enable = 1'b1;
        tick();
        check("frz_c2", act0(), A_REM);
        tick();
        check("frz_c3", act0(), A_REM);
        tick();
        check("frz_fwd", act0(), A_FWD);
        check("frz_rcnt", rc0, 2);
        check("frz_acnt2", ac0, 16);

        // boxed in: four turn_O then stuck
        do_reset(9'd0);
        sense(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("stall_r_tl", act1(), A_TL);
            check("stall_l_tr", act0(), A_TR);
        end
        check("stall_pre_done", done1, 0);
        tick();
        check("stall_act", act1(), A_NONE);
        check("stall_done", done1, 1);
        check("stall_stuck", stuck1, 1);
        check("stall_acnt", ac1, 4);
        tick();
        check("stall_hold", act1(), A_NONE);

        // move budget in a free corridor
        do_reset(9'd3);
        sense(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bud_fwd", act0(), A_FWD);
        end
        check("bud_pre_done", done0, 0);
        tick();
        check("bud_act", act0(), A_NONE);
        check("bud_done", done0, 1);
        check("bud_stuck", stuck0, 0);
        check("bud_acnt", ac0, 3);

        // reset mid-removal abandons it
        do_reset(9'd0);
        sense(1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        tick();
        check("rrst_rem", act0(), A_REM);
        reset = 1'b1;
        tick();
        check("rrst_act", act0(), A_NONE);
        check("rrst_rcnt", rc0, 0);
        check("rrst_acnt", ac0, 0);
        reset = 1'b0;
        sense(1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        check("rrst_walk", act0(), A_FWD);

        // target underneath
        sense(1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        check("tgt_act", act0(), A_NONE);
        tick();
        check("tgt_done", done0, 1);
        check("tgt_stuck", stuck0, 0);
        check("tgt_acnt", ac0, 1);

        // budget coinciding with stall reports stuck
        do_reset(9'd4);
        sense(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (5) tick();
        check("bst_done", done0, 1);
        check("bst_stuck", stuck0, 1);
        check("bst_acnt", ac0, 4);

        // budget truncates a removal
        do_reset(9'd2);
        sense(1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        tick();
        check("btr_rem", act0(), A_REM);
        tick();
        check("btr_act", act0(), A_NONE);
        check("btr_rcnt", rc0, 0);
        tick();
        check("btr_done", done0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
